// File: rtl/mdio_phy_responder.sv
// PHY-side MDIO management responder: decodes preamble-less clause-22 frames
// sampled from an oversampled MDC, writes to / reads from a local register file.
module mdio_phy_responder #(
    parameter logic [4:0] PHY_ADDR    = 5'd0,
    parameter int         TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oe,
    output logic [4:0]  reg_addr,
    output logic [15:0] reg_wr_data,
    output logic        reg_wr_stb,
    output logic        reg_rd_stb,
    input  logic [15:0] reg_rd_data,
    output logic        busy,
    output logic        frame_err
);

    // state   | meaning
    // IDLE    | hunting for ST=01 in a 2-bit window
    // HDR     | collecting OP, PHYAD, REGAD (12 bits)
    // WR_TA   | write turnaround, 2 bits ignored
    // WR_DATA | shifting in 16 write-data bits
    // RD_TA   | read turnaround, drive 0 during second bit
    // RD_DATA | driving 16 read-data bits MSB first
    // SKIP    | frame not for us, consume remaining 18 bits
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] HDR     = 3'd1;
    localparam logic [2:0] WR_TA   = 3'd2;
    localparam logic [2:0] WR_DATA = 3'd3;
    localparam logic [2:0] RD_TA   = 3'd4;
    localparam logic [2:0] RD_DATA = 3'd5;
    localparam logic [2:0] SKIP    = 3'd6;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          mdc_s1, mdc_s2, mdc_prev;
    logic          mdio_s1, mdio_s2;
    logic [2:0]    state;
    logic [4:0]    bit_cnt;
    logic [1:0]    window;
    logic [15:0]   sh;
    logic [15:0]   rd_sh;
    logic          rd_cap;
    logic [TW-1:0] tmo_cnt;

    logic          mdc_rise, mdc_fall, tmo_hit;
    logic [11:0]   hdr_word;
    logic [1:0]    op;
    logic [4:0]    phyad, regad;

    assign mdc_rise = mdc_s2 & ~mdc_prev;
    assign mdc_fall = ~mdc_s2 & mdc_prev;
    assign hdr_word = {sh[10:0], mdio_s2};
    assign op       = hdr_word[11:10];
    assign phyad    = hdr_word[9:5];
    assign regad    = hdr_word[4:0];
    assign busy     = (state != IDLE);
    assign tmo_hit  = (state != IDLE) && !mdc_rise && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdc_s1      <= 1'b0;
            mdc_s2      <= 1'b0;
            mdc_prev    <= 1'b0;
            mdio_s1     <= 1'b0;
            mdio_s2     <= 1'b0;
        end else begin
            mdc_s1      <= mdc;
            mdc_s2      <= mdc_s1;
            mdc_prev    <= mdc_s2;
            mdio_s1     <= mdio_in;
            mdio_s2     <= mdio_s1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bit_cnt     <= 5'd0;
            window      <= 2'b00;
            sh          <= 16'd0;
            rd_sh       <= 16'd0;
            rd_cap      <= 1'b0;
            tmo_cnt     <= '0;
            mdio_out    <= 1'b0;
            mdio_oe     <= 1'b0;
            reg_addr    <= 5'd0;
            reg_wr_data <= 16'd0;
            reg_wr_stb  <= 1'b0;
            reg_rd_stb  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            reg_wr_stb <= 1'b0;
            reg_rd_stb <= 1'b0;
            frame_err  <= 1'b0;
            rd_cap     <= reg_rd_stb;
            // register file answers one clk after the request
            if (rd_cap)
                rd_sh <= reg_rd_data;

            if (state == IDLE || mdc_rise)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TW'(1);

            if (tmo_hit) begin
                state     <= IDLE;
                bit_cnt   <= 5'd0;
                window    <= 2'b00;
                mdio_oe   <= 1'b0;
                mdio_out  <= 1'b0;
                frame_err <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (mdc_rise) begin
                            if ({window[0], mdio_s2} == 2'b01) begin
                                state   <= HDR;
                                bit_cnt <= 5'd0;
                                window  <= 2'b00;
                            end else begin
                                window  <= {window[0], mdio_s2};
                            end
                        end
                    end
                    HDR: begin
                        if (mdc_rise) begin
                            sh <= {sh[14:0], mdio_s2};
                            if (bit_cnt == 5'd11) begin
                                bit_cnt <= 5'd0;
                                if (phyad == PHY_ADDR && op == 2'b01) begin
                                    state    <= WR_TA;
                                    reg_addr <= regad;
                                end else if (phyad == PHY_ADDR && op == 2'b10) begin
                                    state      <= RD_TA;
                                    reg_addr   <= regad;
                                    reg_rd_stb <= 1'b1;
                                end else begin
                                    state     <= SKIP;
                                    bit_cnt   <= 5'd18;
                                    frame_err <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    WR_TA: begin
                        if (mdc_rise) begin
                            if (bit_cnt == 5'd1) begin
                                state   <= WR_DATA;
                                bit_cnt <= 5'd0;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    WR_DATA: begin
                        if (mdc_rise) begin
                            sh <= {sh[14:0], mdio_s2};
                            if (bit_cnt == 5'd15) begin
                                reg_wr_data <= {sh[14:0], mdio_s2};
                                reg_wr_stb  <= 1'b1;
                                state       <= IDLE;
                                bit_cnt     <= 5'd0;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    RD_TA: begin
                        if (mdc_fall && bit_cnt == 5'd1) begin
                            mdio_oe  <= 1'b1;
                            mdio_out <= 1'b0;
                        end
                        if (mdc_rise) begin
                            if (bit_cnt == 5'd1) begin
                                state   <= RD_DATA;
                                bit_cnt <= 5'd0;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (mdc_fall) begin
                            if (bit_cnt == 5'd16) begin
                                mdio_oe  <= 1'b0;
                                mdio_out <= 1'b0;
                                state    <= IDLE;
                                bit_cnt  <= 5'd0;
                            end else begin
                                mdio_out <= rd_sh[15];
                                rd_sh    <= {rd_sh[14:0], 1'b0};
                            end
                        end
                        if (mdc_rise && bit_cnt != 5'd16)
                            bit_cnt <= bit_cnt + 5'd1;
                    end
                    SKIP: begin
                        if (mdc_rise) begin
                            if (bit_cnt == 5'd1) begin
                                state   <= IDLE;
                                bit_cnt <= 5'd0;
                            end else begin
                                bit_cnt <= bit_cnt - 5'd1;
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        bit_cnt <= 5'd0;
                        mdio_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: bit-banged MDIO master plus a
// strobe monitor and a one-word register-file read model.
module tb_mdio_phy_responder;

    localparam logic [4:0] PHY = 5'd3;
    localparam int         H   = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mdc = 1'b0;
    logic        mdio_in = 1'b0;
    logic [15:0] reg_rd_data = 16'd0;
    logic        mdio_out, mdio_oe, reg_wr_stb, reg_rd_stb, busy, frame_err;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wr_data;

    always #5 clk = ~clk;

    mdio_phy_responder #(.PHY_ADDR(PHY), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .reset(reset), .mdc(mdc), .mdio_in(mdio_in),
        .mdio_out(mdio_out), .mdio_oe(mdio_oe), .reg_addr(reg_addr),
        .reg_wr_data(reg_wr_data), .reg_wr_stb(reg_wr_stb), .reg_rd_stb(reg_rd_stb),
        .reg_rd_data(reg_rd_data), .busy(busy), .frame_err(frame_err)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0, oe_cnt = 0, both_cnt = 0;
    logic [4:0]  wr_addr = 5'd0, rd_addr = 5'd0;
    logic [15:0] wr_data = 16'd0;
    logic [15:0] rd_value = 16'h1234;

    always @(negedge clk) begin
        if (reg_wr_stb) begin
            wr_cnt++;
            wr_addr = reg_addr;
            wr_data = reg_wr_data;
        end
        if (reg_rd_stb) begin
            rd_cnt++;
            rd_addr = reg_addr;
            reg_rd_data = rd_value;
        end
        if (reg_wr_stb && reg_rd_stb) both_cnt++;
        if (frame_err) err_cnt++;
        if (mdio_oe) oe_cnt++;
    end

    logic smp_oe [32];
    logic smp_out [32];
    logic smp_busy [32];

    task automatic send_bit(input logic b, input int idx);
        @(negedge clk);
        mdio_in = b;
        repeat (H) @(negedge clk);
        smp_oe[idx]   = mdio_oe;
        smp_out[idx]  = mdio_out;
        smp_busy[idx] = busy;
        mdc = 1'b1;
        repeat (H) @(negedge clk);
        mdc = 1'b0;
    endtask

    task automatic send_frame(input logic [1:0] op, input logic [4:0] pa, input logic [4:0] ra,
                              input logic [15:0] d, input int nbits);
        logic [31:0] f;
        f = {2'b01, op, pa, ra, 2'b10, d};
        for (int i = 0; i < nbits; i++) send_bit(f[31-i], i);
        repeat (2 * H) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    int w0, r0, e0, o0;
    logic [15:0] word;
    int oe_hi;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_oe", mdio_oe, 1'b0);
        chk("rst_out", mdio_out, 1'b0);
        chk("rst_busy_err", {busy, frame_err, reg_wr_stb, reg_rd_stb}, 4'b0000);
        chk("rst_addr_data", {reg_addr, reg_wr_data}, 21'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // write to our address
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; o0 = oe_cnt;
        send_frame(2'b01, PHY, 5'h0A, 16'hBEEF, 32);
        chk("wr_stb_count", wr_cnt - w0, 1);
        chk("wr_addr", wr_addr, 5'h0A);
        chk("wr_data", wr_data, 16'hBEEF);
        chk("wr_no_rd", rd_cnt - r0, 0);
        chk("wr_no_err", err_cnt - e0, 0);
        chk("wr_oe_quiet", oe_cnt - o0, 0);
        chk("wr_idle", busy, 1'b0);

        // read from our address
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        send_frame(2'b10, PHY, 5'h02, 16'hFFFF, 32);
        chk("rd_stb_count", rd_cnt - r0, 1);
        chk("rd_addr", rd_addr, 5'h02);
        chk("rd_ta1_oe", smp_oe[14], 1'b0);
        chk("rd_ta2_oe_out", {smp_oe[15], smp_out[15]}, 2'b10);
        word = 16'd0;
        oe_hi = 0;
        for (int i = 16; i < 32; i++) begin
            word[31-i] = smp_out[i];
            if (smp_oe[i]) oe_hi++;
        end
        chk("rd_data_word", word, 16'h1234);
        chk("rd_data_oe", oe_hi, 16);
        chk("rd_oe_release", mdio_oe, 1'b0);
        chk("rd_no_wr_err", {wr_cnt - w0, err_cnt - e0}, 0);

        // write to another PHY, then a valid write right behind it
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt; o0 = oe_cnt;
        send_frame(2'b01, 5'd7, 5'h0A, 16'h5555, 32);
        chk("mis_err", err_cnt - e0, 1);
        chk("mis_no_stb", (wr_cnt - w0) + (rd_cnt - r0), 0);
        chk("mis_oe_quiet", oe_cnt - o0, 0);
        chk("mis_busy_last_bit", smp_busy[31], 1'b1);
        chk("mis_busy_after", busy, 1'b0);
        send_frame(2'b01, PHY, 5'h11, 16'hA5C3, 32);
        chk("mis_next_wr_count", wr_cnt - w0, 1);
        chk("mis_next_wr", {wr_addr, wr_data}, {5'h11, 16'hA5C3});

        // OP=00 is not ours
        w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
        send_frame(2'b00, PHY, 5'h04, 16'h0001, 32);
        chk("op00_err", err_cnt - e0, 1);
        chk("op00_no_stb", (wr_cnt - w0) + (rd_cnt - r0), 0);

        // MDC stops after 10 bits of a write
        w0 = wr_cnt; e0 = err_cnt;
        send_frame(2'b01, PHY, 5'h06, 16'h1111, 10);
        repeat (30) @(negedge clk);
        chk("tmo_not_yet", {busy, 8'(err_cnt - e0)}, {1'b1, 8'd0});
        repeat (50) @(negedge clk);
        chk("tmo_err", err_cnt - e0, 1);
        chk("tmo_busy", busy, 1'b0);
        chk("tmo_no_wr", wr_cnt - w0, 0);

        // reset in the middle of read data
        w0 = wr_cnt;
        send_frame(2'b10, PHY, 5'h05, 16'hFFFF, 21);
        chk("mid_rd_oe", mdio_oe, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_oe_out", {mdio_oe, mdio_out}, 2'b00);
        chk("mid_rst_busy", {busy, frame_err, reg_wr_stb, reg_rd_stb}, 4'b0000);
        chk("mid_rst_addr_data", {reg_addr, reg_wr_data}, 21'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(2'b01, PHY, 5'h1C, 16'h0F0F, 32);
        chk("post_rst_wr_count", wr_cnt - w0, 1);
        chk("post_rst_wr", {wr_addr, wr_data}, {5'h1C, 16'h0F0F});
        chk("never_both_stb", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
